// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB request master.
// State encoding and bus data width live here.
package apb_master_pkg;

    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/apb_req_master_if.sv
// Request/response handshake plus APB3 requester signals.
// master: the bridge view; slave: the requester/completer view.
interface apb_req_master_if
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12
);

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic                      req_write_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding request to APB3 transfer bridge.
// Misaligned requests fail locally; stalled slaves time out.
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    apb_req_master_if.master bus
);

    // A zero timeout still needs a legal (1-bit) counter.
    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    apb_state_e                state;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rsp_valid_q;
    logic                      rsp_err_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic [CW-1:0]             wait_cnt;
    logic                      timeout;

    // The stall that would bring the count to the limit ends ACCESS.
    assign timeout = (TIMEOUT_CYCLES > 0) && !bus.PREADY &&
                     (wait_cnt == CNT_LAST);

    assign bus.req_ready_o = (state == IDLE);
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state       <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (bus.req_addr_i[1:0] == 2'b00) begin
                            paddr_q  <= bus.req_addr_i;
                            pwrite_q <= bus.req_write_i;
                            pwdata_q <= bus.req_wdata_i;
                            psel_q   <= 1'b1;
                            state    <= SETUP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.PSLVERR;
                        rsp_rdata_q <= (!pwrite_q && !bus.PSLVERR) ?
                                       bus.PRDATA : '0;
                        state       <= RESP;
                    end else begin
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (timeout) begin
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: fixed vectors, reset corners,
// then random transfers checked against a rule-level model.
module tb_apb_req_master;

    localparam int AW = 12;
    localparam int TO = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [31:0]   wdata;
        logic [31:0]   prdata;
        int            waits;
        logic          slverr;
        int            rdelay;
        logic          exp_err;
        logic [31:0]   exp_rdata;
        int            exp_pen;
        int            exp_lat;
    } vec_t;

    logic HCLK;
    logic HRESETn;
    int   n_tests;
    int   n_fail;

    logic [AW-1:0] last_addr;
    logic [31:0]   last_wdata;
    logic          last_write;

    vec_t tbl[9];

    apb_req_master_if #(.APB_ADDR_WIDTH(AW)) bus ();

    apb_req_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    // Outcome of one request derived directly from the rules.
    function automatic void model(input vec_t v,
                                  output logic err,
                                  output logic [31:0] rdata,
                                  output int pen,
                                  output int lat);
        if (v.addr[1:0] != 2'b00) begin
            err = 1'b1; rdata = 32'h0; pen = 0; lat = 1;
        end else if (v.waits >= TO) begin
            err = 1'b1; rdata = 32'h0; pen = TO; lat = TO + 2;
        end else begin
            pen   = v.waits + 1;
            lat   = pen + 2;
            err   = v.slverr;
            rdata = (!v.write && !v.slverr) ? v.prdata : 32'h0;
        end
    endfunction

    task automatic run_txn(input string nm, input vec_t v);
        int pen, psl, lat, acc, busy_rdy, bad_hold, bad_stab;
        bit seen;
        logic [31:0] rd;
        logic er;
        pen = 0; psl = 0; lat = 0; acc = 0;
        busy_rdy = 0; bad_hold = 0; bad_stab = 0; seen = 0;
        chk({nm, ":ready_idle"}, 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = v.addr;
        bus.req_write_i = v.write;
        bus.req_wdata_i = v.wdata;
        @(negedge HCLK);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = AW'($urandom);
        bus.req_wdata_i = $urandom;
        bus.req_write_i = ~v.write;
        bus.rsp_ready_i = 1'b1;
        for (int c = 1; c <= 300 && !seen; c++) begin
            if (bus.rsp_valid_o) begin
                seen = 1;
                lat  = c;
            end else begin
                if (bus.req_ready_o) busy_rdy++;
                if (bus.PSEL) begin
                    psl++;
                    if (bus.PADDR !== v.addr ||
                        bus.PWRITE !== v.write ||
                        bus.PWDATA !== v.wdata) bad_hold++;
                end
                if (bus.PSEL && bus.PENABLE) begin
                    pen++;
                    bus.PREADY  = (acc >= v.waits);
                    bus.PSLVERR = v.slverr;
                    bus.PRDATA  = v.prdata;
                    acc++;
                end else begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = 1'b1;
                    bus.PRDATA  = $urandom;
                end
                @(negedge HCLK);
            end
        end
        chk({nm, ":rsp_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({nm, ":latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, ":penable_cycles"}, 32'(pen), 32'(v.exp_pen));
        chk({nm, ":psel_cycles"}, 32'(psl),
            32'(v.exp_pen + ((v.exp_pen > 0) ? 1 : 0)));
        chk({nm, ":ready_busy"}, 32'(busy_rdy), 32'd0);
        chk({nm, ":bus_hold"}, 32'(bad_hold), 32'd0);
        chk({nm, ":psel_resp"}, 32'(bus.PSEL), 32'd0);
        chk({nm, ":penable_resp"}, 32'(bus.PENABLE), 32'd0);
        chk({nm, ":err"}, 32'(bus.rsp_err_o), 32'(v.exp_err));
        chk({nm, ":rdata"}, bus.rsp_rdata_o, v.exp_rdata);
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        for (int d = 0; d < v.rdelay; d++) begin
            bus.rsp_ready_i = 1'b0;
            @(negedge HCLK);
            if (!bus.rsp_valid_o || bus.rsp_rdata_o !== rd ||
                bus.rsp_err_o !== er || bus.req_ready_o ||
                bus.PSEL) bad_stab++;
        end
        chk({nm, ":rsp_stable"}, 32'(bad_stab), 32'd0);
        bus.rsp_ready_i = 1'b1;
        @(negedge HCLK);
        bus.rsp_ready_i = 1'b0;
        chk({nm, ":rsp_drop"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({nm, ":ready_back"}, 32'(bus.req_ready_o), 32'd1);
        if (v.addr[1:0] == 2'b00) begin
            last_addr  = v.addr;
            last_wdata = v.wdata;
            last_write = v.write;
        end
        chk({nm, ":paddr_idle"}, 32'(bus.PADDR), 32'(last_addr));
        chk({nm, ":pwdata_idle"}, bus.PWDATA, last_wdata);
        chk({nm, ":pwrite_idle"}, 32'(bus.PWRITE), 32'(last_write));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ":psel"}, 32'(bus.PSEL), 32'd0);
        chk({nm, ":penable"}, 32'(bus.PENABLE), 32'd0);
        chk({nm, ":pwrite"}, 32'(bus.PWRITE), 32'd0);
        chk({nm, ":paddr"}, 32'(bus.PADDR), 32'd0);
        chk({nm, ":pwdata"}, bus.PWDATA, 32'd0);
        chk({nm, ":rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({nm, ":rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
        chk({nm, ":rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
    endtask

    initial begin
        vec_t r;
        n_tests = 0;
        n_fail  = 0;
        last_addr  = '0;
        last_wdata = '0;
        last_write = 1'b0;

        tbl[0] = '{12'h008, 1'b1, 32'hDEADBEEF, 32'h12345678,
                   0, 1'b0, 0, 1'b0, 32'h0, 1, 3};
        tbl[1] = '{12'h004, 1'b0, 32'h0, 32'h0000A5A5,
                   3, 1'b0, 1, 1'b0, 32'h0000A5A5, 4, 6};
        tbl[2] = '{12'h010, 1'b0, 32'h0, 32'hFFFF0000,
                   0, 1'b1, 5, 1'b1, 32'h0, 1, 3};
        tbl[3] = '{12'h020, 1'b0, 32'h0, 32'h0,
                   255, 1'b0, 0, 1'b1, 32'h0, 4, 6};
        tbl[4] = '{12'h00C, 1'b0, 32'h0, 32'h0BADF00D,
                   3, 1'b0, 0, 1'b0, 32'h0BADF00D, 4, 6};
        tbl[5] = '{12'h006, 1'b1, 32'hCAFEF00D, 32'h0,
                   0, 1'b0, 2, 1'b1, 32'h0, 0, 1};
        tbl[6] = '{12'hFFC, 1'b1, 32'h01020304, 32'h0,
                   2, 1'b1, 0, 1'b1, 32'h0, 3, 5};
        tbl[7] = '{12'h001, 1'b0, 32'h0, 32'h0,
                   0, 1'b0, 0, 1'b1, 32'h0, 0, 1};
        tbl[8] = '{12'h020, 1'b0, 32'h0, 32'h55AA55AA,
                   4, 1'b0, 0, 1'b1, 32'h0, 4, 6};

        HRESETn         = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.PRDATA      = '0;
        bus.PREADY      = 1'b0;
        bus.PSLVERR     = 1'b0;
        repeat (3) @(negedge HCLK);
        chk_reset_vals("in_reset");
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("post_reset:req_ready", 32'(bus.req_ready_o), 32'd1);
        chk_reset_vals("post_reset");

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of an ACCESS phase.
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 12'h040;
        bus.req_write_i = 1'b1;
        bus.req_wdata_i = 32'h11112222;
        @(negedge HCLK);
        bus.req_valid_i = 1'b0;
        bus.PREADY      = 1'b0;
        chk("rst_mid:setup", 32'({bus.PSEL, bus.PENABLE}), 32'd2);
        @(negedge HCLK);
        chk("rst_mid:access", 32'({bus.PSEL, bus.PENABLE}), 32'd3);
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk_reset_vals("rst_mid");
        HRESETn = 1'b1;
        bus.PREADY = 1'b1;
        @(negedge HCLK);
        chk("rst_mid:req_ready", 32'(bus.req_ready_o), 32'd1);
        last_addr  = '0;
        last_wdata = '0;
        last_write = 1'b0;
        run_txn("after_rst", tbl[0]);

        for (int i = 0; i < 40; i++) begin
            r.addr = AW'($urandom);
            if ($urandom_range(0, 3) != 0) r.addr[1:0] = 2'b00;
            r.write  = 1'($urandom);
            r.wdata  = $urandom;
            r.prdata = $urandom;
            r.waits  = $urandom_range(0, 6);
            r.slverr = ($urandom_range(0, 3) == 0);
            r.rdelay = $urandom_range(0, 3);
            model(r, r.exp_err, r.exp_rdata, r.exp_pen, r.exp_lat);
            run_txn($sformatf("rnd%0d", i), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles without PREADY; 0 disables the timeout.
REQ-003 SHALL have port HCLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-007 SHALL have port req_addr_i  input  APB_ADDR_WIDTH  byte address.
REQ-008 SHALL have port req_write_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_wdata_i  input  32  write data.
REQ-010 SHALL have port rsp_valid_o  output  1  response present.
REQ-011 SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-012 SHALL have port rsp_rdata_o  output  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err_o  output  1  PSLVERR, timeout, or misalignment.
REQ-014 SHALL have ports PADDR (output, APB_ADDR_WIDTH), PWDATA (output, 32), PWRITE (output, 1), PSEL (output, 1), PENABLE (output, 1), PRDATA (input, 32), PREADY (input, 1) and PSLVERR (input, 1), carrying APB3 requester signals.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-016 SHALL drive req_ready_o high only in IDLE.
REQ-017 In IDLE, on req_valid_i high with req_addr_i[1:0]==0, SHALL latch addr, write and wdata, then go to SETUP.
REQ-018 In IDLE, on req_valid_i high with req_addr_i[1:0]!=0, SHALL accept the request without any APB transfer and go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-019 In SETUP, SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-020 In ACCESS, SHALL drive PSEL=1 and PENABLE=1, holding PADDR, PWRITE and PWDATA constant from SETUP until exit.
REQ-021 In ACCESS, on PREADY=1, SHALL register rsp_err_o=PSLVERR and rsp_rdata_o=(read and not PSLVERR ? PRDATA : 0), then go to RESP.
REQ-022 SHALL count ACCESS cycles with PREADY=0.
REQ-023 When TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES, SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, deasserting PSEL and PENABLE on the next cycle.
REQ-024 On a cycle where PREADY and the timeout occur together, SHALL let PREADY win.
REQ-025 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, cleared on entry to ACCESS, and saturating (no wrap).
REQ-026 In RESP, SHALL hold rsp_valid_o=1 with stable data until rsp_ready_i=1, then go to IDLE.
REQ-027 rsp_ready_i SHALL have no effect outside RESP.
REQ-028 Latency: request accepted at edge N SHALL give SETUP at N+1, ACCESS at N+2 and, with zero-wait PREADY, rsp_valid_o at N+3.
REQ-029 A new request SHALL be accepted no earlier than the cycle after the response handshake (4-cycle minimum throughput).
REQ-030 PSEL, PENABLE and rsp_valid_o SHALL be registered outputs.
REQ-031 PADDR, PWRITE and PWDATA SHALL hold their last latched values when idle.
REQ-032 Bus inputs SHALL be ignored outside ACCESS.

Reset
REQ-033 On HRESETn low at a rising edge, SHALL enter IDLE, including mid-SETUP or mid-ACCESS, aborting the transfer with no response.
REQ-034 Reset values SHALL be: req_ready_o=1 in the first cycle after release; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; timeout counter=0.

Structure
REQ-035 Package apb_master_pkg SHALL hold the FSM state enum typedef and the APB data-width constant (32).
REQ-036 SHALL have no sub-module; FSM, counter and registers live in one module.

Verification
REQ-037 Write 0x008, data 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=0x008, PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid_o at N+3, rsp_err_o=0, rsp_rdata_o=0.
REQ-038 Read 0x004, PREADY low for 3 ACCESS cycles, PRDATA=0x0000A5A5 -> PENABLE high 4 cycles; rsp_rdata_o=0x0000A5A5, rsp_err_o=0.
REQ-039 Read with PREADY=1 and PSLVERR=1 -> rsp_err_o=1, rsp_rdata_o=0; rsp_ready_i held low 5 cycles -> response stable, req_ready_o low throughout.
REQ-040 TIMEOUT_CYCLES=4, PREADY never asserted -> rsp_err_o=1 after 4 ACCESS cycles, PSEL low next cycle; separately, PREADY on the 4th cycle -> normal response.
REQ-041 Request to 0x006 -> PSEL never asserted, rsp_valid_o next cycle with rsp_err_o=1.
REQ-042 HRESETn low during ACCESS -> PSEL=0, PENABLE=0, rsp_valid_o=0 after the edge; a subsequent write completes normally.
